cw305_stream_hostif: RTL

//  Register-mapped host-to-DUT streaming bridge for CW305 targets; successor to the ad-hoc VALID/READY regs in the host interface.

---
 rtl/cw305_stream_hostif_pkg.sv | 29 ++
 rtl/cw305_stream_hostif_fifo.sv | 59 +++++
 rtl/cw305_stream_hostif.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cw305_stream_hostif_pkg.sv
// Shared register map, control/status bit positions and run-FSM encoding
// for the CW305 host-to-DUT streaming bridge.
package cw305_stream_hostif_pkg;

  localparam int REG_STREAM_CTRL   = 'h30;
  localparam int REG_STREAM_STATUS = 'h31;
  localparam int REG_STREAM_LEN    = 'h32;
  localparam int REG_STREAM_TXDATA = 'h33;
  localparam int REG_STREAM_RXDATA = 'h34;
  localparam int REG_STREAM_LEVEL  = 'h35;

  localparam int CTRL_START    = 0;
  localparam int CTRL_FLUSH_TX = 1;
  localparam int CTRL_FLUSH_RX = 2;
  localparam int CTRL_DUT_RST  = 3;
  localparam int CTRL_ABORT    = 4;
  localparam int CTRL_CLR_ERR  = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } run_state_e;

  function automatic logic [7:0] sat8(input int unsigned v);
    return (v > 255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/cw305_stream_hostif_fifo.sv
// Show-ahead synchronous FIFO with occupancy level and a single-cycle flush.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module stream_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];
  assign level   = cnt;

  // NOTE: storage carries no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cw305_stream_hostif.sv
// Register-mapped bridge: byte-wise host writes feed a TX FIFO streamed to the DUT,
// DUT results land in an RX FIFO that the host drains byte-wise.
module cw305_stream_hostif
  import cw305_stream_hostif_pkg::*;
#(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pW            = 64,
  parameter int pOUTPUT_W     = 4,
  parameter int pCOEFF_W      = 23,
  parameter int pTX_DEPTH     = 16,
  parameter int pRX_DEPTH     = 16,
  parameter int pLEN_W        = 16
) (
  input  logic                               usb_clk,
  input  logic                               reset_n_i,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  input  logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
  input  logic [7:0]                         write_data,
  output logic [7:0]                         read_data,
  input  logic                               reg_read,
  input  logic                               reg_write,
  input  logic                               reg_addrvalid,
  output logic [pW-1:0]                      o_di,
  output logic                               VALID_TO_DUT,
  input  logic                               READY_FROM_DUT,
  input  logic [pOUTPUT_W*pCOEFF_W-1:0]      i_samples,
  input  logic                               VALID_FROM_DUT,
  output logic                               READY_TO_DUT,
  output logic                               oRESET,
  output logic                               o_done
);

  localparam int ADDR_W    = pADDR_WIDTH - pBYTECNT_SIZE;
  localparam int TX_BYTES  = pW / 8;
  localparam int RX_W      = pOUTPUT_W * pCOEFF_W;
  localparam int RX_BYTES  = (RX_W + 7) / 8;
  localparam int LEN_BYTES = (pLEN_W + 7) / 8;

  logic wr, rd, rd_q, rd_rise;
  logic sel_ctrl, sel_status, sel_len, sel_tx, sel_rx, sel_level;
  logic start_cmd, flush_tx, flush_rx, dut_rst_cmd, abort_cmd, clr_cmd, kill;

  assign wr      = reg_addrvalid & reg_write;
  assign rd      = reg_addrvalid & reg_read;
  assign rd_rise = rd & ~rd_q;

  assign sel_ctrl   = (reg_address == ADDR_W'(REG_STREAM_CTRL));
  assign sel_status = (reg_address == ADDR_W'(REG_STREAM_STATUS));
  assign sel_len    = (reg_address == ADDR_W'(REG_STREAM_LEN));
  assign sel_tx     = (reg_address == ADDR_W'(REG_STREAM_TXDATA));
  assign sel_rx     = (reg_address == ADDR_W'(REG_STREAM_RXDATA));
  assign sel_level  = (reg_address == ADDR_W'(REG_STREAM_LEVEL));

  assign start_cmd   = wr & sel_ctrl & write_data[CTRL_START];
  assign flush_tx    = wr & sel_ctrl & write_data[CTRL_FLUSH_TX];
  assign flush_rx    = wr & sel_ctrl & write_data[CTRL_FLUSH_RX];
  assign dut_rst_cmd = wr & sel_ctrl & write_data[CTRL_DUT_RST];
  assign abort_cmd   = wr & sel_ctrl & write_data[CTRL_ABORT];
  assign clr_cmd     = wr & sel_ctrl & write_data[CTRL_CLR_ERR];
  assign kill        = abort_cmd | dut_rst_cmd;

  run_state_e state, state_nxt;
  logic [pW-1:0]              stage, tx_word, tx_head;
  logic [RX_W-1:0]            rx_head;
  logic [RX_BYTES*8-1:0]      rx_pad;
  logic [$clog2(pTX_DEPTH):0] tx_level;
  logic [$clog2(pRX_DEPTH):0] rx_level;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, tx_valid, rx_ready, busy;
  logic err_tx_ovf, err_rx_unf;
  logic [LEN_BYTES*8-1:0]     len_reg;
  logic [pLEN_W-1:0]          rx_cnt;
  logic [pLEN_W:0]            rx_cnt_nxt, len_eff;
  logic [7:0]                 rd_mux;

  // The last TX byte completes the word combinationally so it can be pushed that same cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    tx_word = stage;
    for (int b = 0; b < TX_BYTES; b++)
      if (reg_bytecnt == pBYTECNT_SIZE'(b)) tx_word[b*8 +: 8] = write_data;
  end

  assign tx_push  = wr & sel_tx & (reg_bytecnt == pBYTECNT_SIZE'(TX_BYTES-1));
  assign busy     = (state == S_RUN);
  assign tx_valid = busy & ~tx_empty & ~flush_tx & ~kill;
  assign rx_ready = busy & ~rx_full & ~flush_rx & ~kill;
  assign tx_pop   = tx_valid & READY_FROM_DUT;
  assign rx_push  = rx_ready & VALID_FROM_DUT;
  assign rx_pop   = rd_rise & sel_rx & (reg_bytecnt == pBYTECNT_SIZE'(RX_BYTES-1)) & ~rx_empty;

  stream_sync_fifo #(.WIDTH(pW), .DEPTH(pTX_DEPTH)) u_tx_fifo (
    .clk(usb_clk), .rst_n(reset_n_i), .flush(flush_tx),
    .push(tx_push), .din(tx_word), .pop(tx_pop), .dout(tx_head),
    .level(tx_level), .full(tx_full), .empty(tx_empty)
  );

  stream_sync_fifo #(.WIDTH(RX_W), .DEPTH(pRX_DEPTH)) u_rx_fifo (
    .clk(usb_clk), .rst_n(reset_n_i), .flush(flush_rx),
    .push(rx_push), .din(i_samples), .pop(rx_pop), .dout(rx_head),
    .level(rx_level), .full(rx_full), .empty(rx_empty)
  );

  assign rx_cnt_nxt = {1'b0, rx_cnt} + (pLEN_W+1)'(rx_push);
  assign len_eff    = (len_reg[pLEN_W-1:0] == '0) ? (pLEN_W+1)'(1) : {1'b0, len_reg[pLEN_W-1:0]};

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start_cmd) state_nxt = S_RUN;
      S_RUN:          if (rx_cnt_nxt >= len_eff) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge usb_clk or negedge reset_n_i) begin
    if (!reset_n_i) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge usb_clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage      <= '0;
      len_reg    <= '0;
      rx_cnt     <= '0;
      err_tx_ovf <= 1'b0;
      err_rx_unf <= 1'b0;
      oRESET     <= 1'b0;
      rd_q       <= 1'b0;
      read_data  <= '0;
    end else begin
      rd_q   <= rd;
      oRESET <= dut_rst_cmd;
      if (rd) read_data <= rd_mux;
      if (dut_rst_cmd)       stage <= '0;
      else if (wr && sel_tx) stage <= tx_word;
      for (int b = 0; b < LEN_BYTES; b++)
        if (wr && sel_len && reg_bytecnt == pBYTECNT_SIZE'(b)) len_reg[b*8 +: 8] <= write_data;
      if (kill || (start_cmd && state != S_RUN)) rx_cnt <= '0;
      else if (rx_push)                          rx_cnt <= rx_cnt + pLEN_W'(1);
      // A fresh error event wins over a clear issued in the same cycle.
      if (tx_push && tx_full && !tx_pop && !flush_tx) err_tx_ovf <= 1'b1;
      else if (clr_cmd)                              err_tx_ovf <= 1'b0;
      if (rd_rise && sel_rx && rx_empty) err_rx_unf <= 1'b1;
      else if (clr_cmd)                  err_rx_unf <= 1'b0;
    end
  end

  assign rx_pad = (RX_BYTES*8)'(rx_head);

  always_comb begin
    rd_mux = '0;
    if (sel_status) begin
      rd_mux = {err_rx_unf, err_tx_ovf, o_done, busy, rx_full, rx_empty, tx_full, tx_empty};
    end else if (sel_len) begin
      for (int b = 0; b < LEN_BYTES; b++)
        if (reg_bytecnt == pBYTECNT_SIZE'(b)) rd_mux = len_reg[b*8 +: 8];
    end else if (sel_rx && !rx_empty) begin
      for (int b = 0; b < RX_BYTES; b++)
        if (reg_bytecnt == pBYTECNT_SIZE'(b)) rd_mux = rx_pad[b*8 +: 8];
    end else if (sel_level) begin
      if (reg_bytecnt == pBYTECNT_SIZE'(0))      rd_mux = sat8(32'(tx_level));
      else if (reg_bytecnt == pBYTECNT_SIZE'(1)) rd_mux = sat8(32'(rx_level));
    end
  end

  assign VALID_TO_DUT = tx_valid;
  assign o_di         = tx_valid ? tx_head : '0;
  assign READY_TO_DUT = rx_ready;
  assign o_done       = (state == S_DONE);

endmodule
